// File: rtl/evp_fsm.sv
// Horner-rule polynomial evaluator reading degree/coefficients from the STP coefficient store.
// Latency 2N+4 edges from start (2 on a degree error); start is accepted only in IDLE.
module evp_fsm #(
    parameter int WORD_SIZE   = 16,
    parameter int BUFFER_SIZE = 1024,
    parameter int MAX_DEG     = 10,
    parameter int AW          = $clog2(BUFFER_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rst_instr,
    input  logic                 start_evp,
    input  logic [2:0]           A,
    input  logic [WORD_SIZE-1:0] x,
    output logic                 en_rd_N,
    output logic [AW-1:0]        rd_addr_N,
    input  logic [4:0]           N_in,
    output logic                 en_rd_S,
    output logic [AW-1:0]        rd_addr_S,
    input  logic [WORD_SIZE-1:0] c_in,
    output logic                 done_evp,
    output logic [31:0]          result,
    output logic [31:0]          status
);
    localparam int STRIDE = MAX_DEG + 1;
    localparam int PW     = 32 + WORD_SIZE;

    typedef enum logic [2:0] {IDLE, RD_N, CHECK_N, FETCH, MAC, DONE} state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   a_q, a_d;
    logic signed [WORD_SIZE-1:0]  x_q, x_d;
    logic signed [31:0]           acc_q, acc_d;
    logic [4:0]                   idx_q, idx_d;
    logic                         en_rd_N_q, en_rd_N_d;
    logic [AW-1:0]                rd_addr_N_q, rd_addr_N_d;
    logic                         en_rd_S_q, en_rd_S_d;
    logic [AW-1:0]                rd_addr_S_q, rd_addr_S_d;
    logic                         done_q, done_d;
    logic [31:0]                  result_q, result_d;
    logic [31:0]                  status_q, status_d;

    logic [AW-1:0]                base;
    logic signed [PW-1:0]         prod;
    logic [PW:0]                  sum;
    logic                         ovf;

    // Full-width Horner step; overflow when the sum does not fit in 32 signed bits.
    always_comb begin
        base = AW'(a_q) * AW'(STRIDE);
        prod = acc_q * x_q;
        sum  = {prod[PW-1], prod} + {{(PW+1-WORD_SIZE){c_in[WORD_SIZE-1]}}, c_in};
        ovf  = !((&sum[PW:31]) || !(|sum[PW:31]));
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        x_d         = x_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        en_rd_N_d   = 1'b0;
        rd_addr_N_d = rd_addr_N_q;
        en_rd_S_d   = 1'b0;
        rd_addr_S_d = rd_addr_S_q;
        done_d      = 1'b0;
        result_d    = result_q;
        status_d    = status_q;
        case (state_q)
            IDLE: begin
                if (start_evp) begin
                    a_d         = A;
                    x_d         = x;
                    en_rd_N_d   = 1'b1;
                    rd_addr_N_d = AW'(A);
                    state_d     = RD_N;
                end
            end
            RD_N: state_d = CHECK_N;
            CHECK_N: begin
                if (N_in > 5'(MAX_DEG)) begin
                    result_d = 32'd0;
                    status_d = 32'd1;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d       = N_in;
                    acc_d       = 32'sd0;
                    status_d    = 32'd0;
                    en_rd_S_d   = 1'b1;
                    rd_addr_S_d = base + AW'(N_in);
                    state_d     = FETCH;
                end
            end
            FETCH: state_d = MAC;
            MAC: begin
                acc_d = sum[31:0];
                if (ovf) status_d = 32'd2;
                if (idx_q == 5'd0) begin
                    result_d = sum[31:0];
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d       = idx_q - 5'd1;
                    en_rd_S_d   = 1'b1;
                    rd_addr_S_d = base + AW'(idx_q - 5'd1);
                    state_d     = FETCH;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            en_rd_N_q   <= 1'b0;
            rd_addr_N_q <= '0;
            en_rd_S_q   <= 1'b0;
            rd_addr_S_q <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
        end else if (!rst_instr) begin
            state_q     <= IDLE;
            a_q         <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            en_rd_N_q   <= 1'b0;
            rd_addr_N_q <= '0;
            en_rd_S_q   <= 1'b0;
            rd_addr_S_q <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            en_rd_N_q   <= en_rd_N_d;
            rd_addr_N_q <= rd_addr_N_d;
            en_rd_S_q   <= en_rd_S_d;
            rd_addr_S_q <= rd_addr_S_d;
            done_q      <= done_d;
            result_q    <= result_d;
            status_q    <= status_d;
        end
    end

    assign en_rd_N   = en_rd_N_q;
    assign rd_addr_N = rd_addr_N_q;
    assign en_rd_S   = en_rd_S_q;
    assign rd_addr_S = rd_addr_S_q;
    assign done_evp  = done_q;
    assign result    = result_q;
    assign status    = status_q;
endmodule
